// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared field widths, default sizing and the writeback payload record
package wb_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W = 6;
  localparam int RD_W = 6;
  localparam int PC_W = 12;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_STARVE_MAX = 7;
  typedef struct packed {
    logic we;
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0] rob;
    logic [RD_W-1:0] rd;
    logic [PC_W-1:0] pc;
  } wb_pay_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: FU request bundle (valid/ready + payload) and writeback port bundle
//   master: functional-unit side, drives req_* payloads, sees req_ready and wb_*
//   slave : arbiter side, returns req_ready and drives wb_*
interface wb_arbiter_if import wb_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_PORTS = DEF_NUM_PORTS
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_we;
  logic [NUM_REQ*DATA_W-1:0] req_res;
  logic [NUM_REQ*TAG_W-1:0] req_rob;
  logic [NUM_REQ*RD_W-1:0] req_rd;
  logic [NUM_REQ*PC_W-1:0] req_pc;
  logic [NUM_PORTS-1:0] wb_valid;
  logic [NUM_PORTS-1:0] wb_we;
  logic [NUM_PORTS*DATA_W-1:0] wb_res;
  logic [NUM_PORTS*TAG_W-1:0] wb_rob;
  logic [NUM_PORTS*RD_W-1:0] wb_rd;
  logic [NUM_PORTS*PC_W-1:0] wb_pc;
  modport master (
    output req_valid, req_we, req_res, req_rob, req_rd, req_pc,
    input req_ready, wb_valid, wb_we, wb_res, wb_rob, wb_rd, wb_pc
  );
  modport slave (
    input req_valid, req_we, req_res, req_rob, req_rd, req_pc,
    output req_ready, wb_valid, wb_we, wb_res, wb_rob, wb_rd, wb_pc
  );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// wb_arbiter_rr_pick: rotating find-first, first set bit of mask_i at or above base_i (mod N)
//   mask_i candidates, base_i start index; onehot_o/idx_o the pick, found_o any candidate
module wb_arbiter_rr_pick import wb_arbiter_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = idx_w(N)
) (
  input logic [N-1:0] mask_i,
  input logic [IW-1:0] base_i,
  output logic [N-1:0] onehot_o,
  output logic [IW-1:0] idx_o,
  output logic found_o
);
  localparam logic [IW:0] NL = (IW+1)'(N);
  logic [IW:0] s;
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the nearest hit to base_i is written last.
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    found_o = 1'b0;
    s = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, base_i} + (IW+1)'(k);
      j = s >= NL ? IW'(s - NL) : IW'(s);
      if (mask_i[j]) begin
        onehot_o = N'(1) << j;
        idx_o = j;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares NUM_PORTS registered writeback ports among NUM_REQ FU requesters
//   clk, rst (sync, active-high), flush (drops this cycle's grants and clears starvation)
//   bus.slave: req_valid/req_ready handshake + payloads in, wb_* registered results out
module wb_arbiter import wb_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic clk,
  input logic rst,
  input logic flush,
  wb_arbiter_if.slave bus
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = idx_w(STARVE_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);
  logic en;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, forced_idx, last_idx;
  logic [NUM_REQ-1:0][CW-1:0] starve_q, starve_d;
  logic [NUM_REQ-1:0] forced_oh, gnt;
  logic forced, rr_any;
  logic [NUM_PORTS-1:0][NUM_REQ-1:0] st_mask, st_oh;
  logic [NUM_PORTS-1:0][IW-1:0] st_idx, port_idx;
  logic [NUM_PORTS-1:0] st_found, port_found;
  logic [NUM_PORTS-1:0] wb_valid_q, wb_valid_d;
  wb_pay_t [NUM_PORTS-1:0] pay_q, pay_d;
  wb_pay_t req_pay [NUM_REQ];
  assign en = ~rst & ~flush;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_pay[g] = '{we: bus.req_we[g], res: bus.req_res[g*DATA_W +: DATA_W],
                          rob: bus.req_rob[g*TAG_W +: TAG_W], rd: bus.req_rd[g*RD_W +: RD_W],
                          pc: bus.req_pc[g*PC_W +: PC_W]};
  end
  // Lowest-index requester whose wait has saturated takes port 0 ahead of the rotation.
  always_comb begin
    forced = 1'b0;
    forced_idx = '0;
    forced_oh = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_valid[i] && starve_q[i] == CMAX) begin
        forced = 1'b1;
        forced_idx = IW'(i);
        forced_oh = NUM_REQ'(1) << i;
      end
  end
  // Round-robin chain: each stage excludes the forced winner and all earlier picks.
  // With a forced grant, port p takes rotation stage p-1, so the last stage goes unused.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    wb_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
      .mask_i(st_mask[p]), .base_i(rr_ptr_q),
      .onehot_o(st_oh[p]), .idx_o(st_idx[p]), .found_o(st_found[p])
    );
    if (p == 0) begin : g_first
      assign st_mask[p] = bus.req_valid & ~forced_oh;
      assign port_found[p] = forced | st_found[p];
      assign port_idx[p] = forced ? forced_idx : st_idx[p];
    end else begin : g_rest
      assign st_mask[p] = st_mask[p-1] & ~st_oh[p-1];
      assign port_found[p] = forced ? st_found[p-1] : st_found[p];
      assign port_idx[p] = forced ? st_idx[p-1] : st_idx[p];
    end
    assign bus.wb_we[p] = pay_q[p].we;
    assign bus.wb_res[p*DATA_W +: DATA_W] = pay_q[p].res;
    assign bus.wb_rob[p*TAG_W +: TAG_W] = pay_q[p].rob;
    assign bus.wb_rd[p*RD_W +: RD_W] = pay_q[p].rd;
    assign bus.wb_pc[p*PC_W +: PC_W] = pay_q[p].pc;
  end
  always_comb begin
    gnt = forced_oh;
    rr_any = 1'b0;
    last_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      if (st_found[p] && (!forced || p < NUM_PORTS - 1)) begin
        gnt = gnt | st_oh[p];
        rr_any = 1'b1;
        last_idx = st_idx[p];
      end
    rr_ptr_d = (en && rr_any) ? (last_idx == IW'(NUM_REQ - 1) ? '0 : last_idx + IW'(1)) : rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++)
      starve_d[i] = (flush || !bus.req_valid[i] || gnt[i]) ? '0 :
                    (starve_q[i] == CMAX ? CMAX : starve_q[i] + CW'(1));
    for (int p = 0; p < NUM_PORTS; p++) begin
      wb_valid_d[p] = en & port_found[p];
      pay_d[p] = wb_valid_d[p] ? req_pay[port_idx[p]] : '0;
    end
  end
  assign bus.req_ready = en ? gnt : '0;
  assign bus.wb_valid = wb_valid_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      starve_q <= '0;
      wb_valid_q <= '0;
      pay_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      starve_q <= starve_d;
      wb_valid_q <= wb_valid_d;
      pay_q <= pay_d;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed + random bench for wb_arbiter with a per-cycle grant/writeback model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int NR = DEF_NUM_REQ;
  localparam int NP = DEF_NUM_PORTS;
  localparam int SM = DEF_STARVE_MAX;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  wb_arbiter_if #(.NUM_REQ(NR), .NUM_PORTS(NP)) bus ();
  wb_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );
  logic [NR-1:0] v = '0;
  logic [NR-1:0] we = '0;
  logic [DATA_W-1:0] res [NR] = '{default: '0};
  logic [TAG_W-1:0] rob [NR] = '{default: '0};
  logic [RD_W-1:0] rd [NR] = '{default: '0};
  logic [PC_W-1:0] pc [NR] = '{default: '0};
  assign bus.req_valid = v;
  assign bus.req_we = we;
  for (genvar g = 0; g < NR; g++) begin : g_drv
    assign bus.req_res[g*DATA_W +: DATA_W] = res[g];
    assign bus.req_rob[g*TAG_W +: TAG_W] = rob[g];
    assign bus.req_rd[g*RD_W +: RD_W] = rd[g];
    assign bus.req_pc[g*PC_W +: PC_W] = pc[g];
  end
  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic put(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] r);
    v[i] = 1'b1;
    we[i] = t[0];
    res[i] = r;
    rob[i] = t;
    rd[i] = ~t;
    pc[i] = {6'h2a, t};
  endtask
  bit chk_on = 0;
  bit pin_rr = 0;
  bit sb_on = 0;
  int m_rr = 0;
  int m_cnt [NR] = '{default: 0};
  int wait_c [NR] = '{default: 0};
  int acc_n = 0;
  int wb_n = 0;
  logic [NR-1:0] acc_last = '0;
  logic [NP-1:0] e_v = '0;
  logic e_we [NP] = '{default: 1'b0};
  logic [DATA_W-1:0] e_res [NP] = '{default: '0};
  logic [TAG_W-1:0] e_rob [NP] = '{default: '0};
  logic [RD_W-1:0] e_rd [NP] = '{default: '0};
  logic [PC_W-1:0] e_pc [NP] = '{default: '0};
  // Model: grant list = saturated requester first, then valid ones scanned from the pointer.
  always @(negedge clk) begin
    int g[$];
    logic [NR-1:0] gm;
    int last;
    bit any;
    g.delete();
    gm = '0;
    last = 0;
    any = 0;
    if (pin_rr) m_rr = 0;
    if (!rst && !flush) begin
      for (int i = 0; i < NR; i++)
        if (v[i] && m_cnt[i] == SM) begin
          g.push_back(i);
          gm[i] = 1'b1;
          break;
        end
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_rr + k) % NR;
        if (v[j] && !gm[j] && g.size() < NP) begin
          g.push_back(j);
          gm[j] = 1'b1;
          last = j;
          any = 1;
        end
      end
    end
    if (chk_on) begin
      chk("req_ready", bus.req_ready, gm);
      chk("wb_valid", bus.wb_valid, e_v);
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("wb%0d_we", p), bus.wb_we[p], e_we[p]);
        chk($sformatf("wb%0d_res", p), bus.wb_res[p*DATA_W +: DATA_W], e_res[p]);
        chk($sformatf("wb%0d_rob", p), bus.wb_rob[p*TAG_W +: TAG_W], e_rob[p]);
        chk($sformatf("wb%0d_rd", p), bus.wb_rd[p*RD_W +: RD_W], e_rd[p]);
        chk($sformatf("wb%0d_pc", p), bus.wb_pc[p*PC_W +: PC_W], e_pc[p]);
      end
    end
    for (int i = 0; i < NR; i++) begin
      wait_c[i] = (v[i] && !bus.req_ready[i] && !rst && !flush) ? wait_c[i] + 1 : 0;
      if (chk_on && v[i]) chk($sformatf("max_wait%0d", i), wait_c[i] > SM + 1, 0);
    end
    if (sb_on) begin
      acc_n += $countones(bus.req_ready & v);
      wb_n += $countones(bus.wb_valid);
    end
    acc_last = bus.req_ready;
    if (rst) begin
      e_v = '0;
      m_rr = 0;
      for (int p = 0; p < NP; p++) begin
        e_we[p] = 1'b0; e_res[p] = '0; e_rob[p] = '0; e_rd[p] = '0; e_pc[p] = '0;
      end
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        e_v[p] = 1'b0; e_we[p] = 1'b0; e_res[p] = '0; e_rob[p] = '0; e_rd[p] = '0; e_pc[p] = '0;
        if (p < g.size()) begin
          e_v[p] = 1'b1;
          e_we[p] = we[g[p]];
          e_res[p] = res[g[p]];
          e_rob[p] = rob[g[p]];
          e_rd[p] = rd[g[p]];
          e_pc[p] = pc[g[p]];
        end
      end
      if (any) m_rr = (last + 1) % NR;
      for (int i = 0; i < NR; i++)
        m_cnt[i] = (flush || !v[i] || gm[i]) ? 0 : (m_cnt[i] < SM ? m_cnt[i] + 1 : SM);
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [TAG_W-1:0] ntag;
    ntag = '0;
    put(0, 6'd1, 32'h1); put(1, 6'd2, 32'h2); put(2, 6'd3, 32'h3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_on = 1;
    chk("rst_ready", bus.req_ready, 3'b000);
    chk("rst_wb_valid", bus.wb_valid, 2'b00);
    // 1: single requester
    @(posedge clk); #1;
    rst = 1'b0; v = '0; put(0, 6'd5, 32'h11);
    @(negedge clk);
    chk("t1_ready", bus.req_ready, 3'b001);
    @(posedge clk); #1;
    v = '0;
    @(negedge clk);
    chk("t1_wb_valid", bus.wb_valid, 2'b01);
    chk("t1_res", bus.wb_res[31:0], 32'h11);
    chk("t1_rob", bus.wb_rob[5:0], 6'd5);
    chk("t1_rr", dut.rr_ptr_q, 1);
    // 2: three requesters from pointer 0
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; put(0, 6'd10, 32'ha); put(1, 6'd11, 32'hb); put(2, 6'd12, 32'hc);
    @(negedge clk);
    chk("t2a_ready", bus.req_ready, 3'b011);
    @(posedge clk); #1;
    put(0, 6'd20, 32'h14); put(1, 6'd21, 32'h15);
    @(negedge clk);
    chk("t2b_ready", bus.req_ready, 3'b101);
    chk("t2b_rob0", bus.wb_rob[5:0], 6'd10);
    chk("t2b_rob1", bus.wb_rob[11:6], 6'd11);
    @(posedge clk); #1;
    v[0] = 1'b0; v[2] = 1'b0;
    @(negedge clk);
    chk("t2c_ready", bus.req_ready, 3'b010);
    chk("t2c_rob0", bus.wb_rob[5:0], 6'd12);
    chk("t2c_rob1", bus.wb_rob[11:6], 6'd20);
    @(posedge clk); #1;
    v = '0;
    @(negedge clk);
    chk("t2d_wb_valid", bus.wb_valid, 2'b01);
    chk("t2d_rob0", bus.wb_rob[5:0], 6'd21);
    // 3: pointer pinned at 0 so req2 loses 7 cycles, then is forced onto port 0
    @(posedge clk); #1;
    force dut.rr_ptr_q = '0;
    pin_rr = 1;
    put(0, 6'd30, 32'h30); put(1, 6'd31, 32'h31); put(2, 6'd32, 32'h32);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 7) chk("t3_lose_ready", bus.req_ready, 3'b011);
      else chk("t3_force_ready", bus.req_ready, 3'b101);
      if (c == 7) begin
        #1;
        release dut.rr_ptr_q;
        pin_rr = 0;
      end
      @(posedge clk); #1;
      if (c < 7) begin
        put(0, 6'(33 + 2 * c), 32'h100 + c);
        put(1, 6'(34 + 2 * c), 32'h200 + c);
      end else begin
        v[0] = 1'b0; v[2] = 1'b0;
      end
    end
    @(negedge clk);
    chk("t3_rob0", bus.wb_rob[5:0], 6'd32);
    chk("t3_cnt", dut.starve_q[2], 0);
    // 4: flush blocks grants for one cycle
    @(posedge clk); #1;
    flush = 1'b1; put(0, 6'd50, 32'h50); put(1, 6'd51, 32'h51); put(2, 6'd52, 32'h52);
    @(negedge clk);
    chk("t4_ready", bus.req_ready, 3'b000);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t4_wb_valid", bus.wb_valid, 2'b00);
    chk("t4_resume", |bus.req_ready, 1'b1);
    // 5: reset with two results in flight
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) if (acc_last[i]) put(i, 6'(53 + i), 32'h53 + i);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready", bus.req_ready, 3'b000);
    chk("t5_inflight", bus.wb_valid, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0; v = '0;
    @(negedge clk);
    chk("t5_wb_valid", bus.wb_valid, 2'b00);
    chk("t5_rr", dut.rr_ptr_q, 0);
    // 6: random valid/stall traffic with occasional flush
    @(posedge clk); #1;
    sb_on = 1;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (v[i] && acc_last[i]) v[i] = 1'b0;
        if (!v[i] && $urandom_range(99) < 60) begin
          put(i, ntag, $urandom);
          ntag = ntag + 1'b1;
        end
      end
      flush = ($urandom_range(49) == 0);
    end
    @(posedge clk); #1;
    v = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    sb_on = 0;
    chk("sb_count", wb_n, acc_n);
    chk("sb_traffic", acc_n > 1000, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
